// File: rtl/aud_pkg.sv
// Shared types and constants for the stereo DAC player.
package aud_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSync  = 2'd1,
    StLeft  = 2'd2,
    StRight = 2'd3
  } aud_state_e;

  localparam int unsigned AUD_MODE_LJ  = 0;
  localparam int unsigned AUD_MODE_I2S = 1;

endpackage

// File: rtl/aud_slot_shifter.sv
// Per-slot serializer: loads a word at the slot edge, optionally idles one bit (I2S), then
// shifts MSB first and drives 0 once the word is exhausted or the shifter is cleared.
module aud_slot_shifter #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic              i_delay,
  input  logic [DATA_W-1:0] i_word,
  output logic              o_bit
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dly_q, dly_d;
  logic              live_q, live_d;

  // Next-state: clear wins, then load (truncating any word in flight), then shift.
  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    dly_d  = dly_q;
    live_d = live_q;
    if (i_clear) begin
      sr_d   = '0;
      cnt_d  = '0;
      dly_d  = 1'b0;
      live_d = 1'b0;
    end else if (i_load) begin
      sr_d   = i_word;
      cnt_d  = CNT_W'(DATA_W - 1);
      dly_d  = i_delay;
      live_d = 1'b1;
    end else if (live_q) begin
      if (dly_q) begin
        dly_d = 1'b0;
      end else if (cnt_q == '0) begin
        live_d = 1'b0;
        sr_d   = '0;
      end else begin
        sr_d  = {sr_q[DATA_W-2:0], 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // Slot state register, updated on the falling bit-clock edge.
  always_ff @(negedge i_clk) begin
    if (i_rst) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      dly_q  <= 1'b0;
      live_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      dly_q  <= dly_d;
      live_q <= live_d;
    end
  end

  assign o_bit = live_q & ~dly_q & sr_q[DATA_W-1];

endmodule

// File: rtl/aud_player_stereo.sv
// Stereo DAC serializer: one-deep sample-pair buffer, LRC-framed left/right slots,
// underrun pulse on an empty frame start. Optional mono downmix under AUD_PLAYER_MONO_EN.
module aud_player_stereo
  import aud_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned I2S_MODE = AUD_MODE_I2S
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_lrc,
  input  logic              i_en,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_left,
  input  logic [DATA_W-1:0] i_right,
`ifdef AUD_PLAYER_MONO_EN
  input  logic              i_mono,
`endif
  output logic              o_aud_dacdat,
  output logic [1:0]        o_state,
  output logic              o_underrun
);

  localparam logic SlotDelay = (I2S_MODE == AUD_MODE_I2S);

  aud_state_e        state_q, state_d;
  logic              lrc_q;
  logic              buf_full_q, buf_full_d;
  logic [DATA_W-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
  logic [DATA_W-1:0] r_word_q, r_word_d;
  logic              underrun_q, underrun_d;

  logic              fall, rise, xfer, frame_start;
  logic              sh_clear, sh_load;
  logic [DATA_W-1:0] sh_word, pair_l, pair_r, out_l, out_r;

  assign fall    = lrc_q & ~i_lrc;
  assign rise    = ~lrc_q & i_lrc;
  assign o_ready = i_en & (state_q != StIdle) & ~buf_full_q;
  assign xfer    = i_valid & o_ready;

  // Pair for a frame start: buffered pair, else the bypassed incoming pair, else silence.
  assign pair_l = buf_full_q ? buf_l_q : (xfer ? i_left : '0);
  assign pair_r = buf_full_q ? buf_r_q : (xfer ? i_right : '0);

`ifdef AUD_PLAYER_MONO_EN
  logic signed [DATA_W:0] mono_sum;
  // One extra bit of headroom, then arithmetic halving: never overflows.
  assign mono_sum = $signed({pair_l[DATA_W-1], pair_l}) + $signed({pair_r[DATA_W-1], pair_r});
  assign out_l    = i_mono ? mono_sum[DATA_W:1] : pair_l;
  assign out_r    = i_mono ? mono_sum[DATA_W:1] : pair_r;
`else
  assign out_l = pair_l;
  assign out_r = pair_r;
`endif

  // FSM next-state, buffer bookkeeping and slot loads.
  always_comb begin
    state_d     = state_q;
    buf_full_d  = buf_full_q;
    buf_l_d     = buf_l_q;
    buf_r_d     = buf_r_q;
    r_word_d    = r_word_q;
    underrun_d  = 1'b0;
    sh_clear    = 1'b0;
    sh_load     = 1'b0;
    sh_word     = out_l;
    frame_start = 1'b0;
    if (!i_en) begin
      state_d    = StIdle;
      buf_full_d = 1'b0;
      r_word_d   = '0;
      sh_clear   = 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          state_d    = StSync;
          buf_full_d = 1'b0;
          sh_clear   = 1'b1;
        end
        StSync, StRight: begin
          if (fall) begin
            frame_start = 1'b1;
            state_d     = StLeft;
          end
        end
        StLeft: begin
          if (rise) begin
            state_d = StRight;
            sh_load = 1'b1;
            sh_word = r_word_q;
          end
        end
        default: state_d = StIdle;
      endcase
      if (frame_start) begin
        sh_load  = 1'b1;
        sh_word  = out_l;
        r_word_d = out_r;
        if (buf_full_q) begin
          buf_full_d = 1'b0;
        end else if (!xfer) begin
          underrun_d = 1'b1;
        end
      end else if (xfer) begin
        buf_full_d = 1'b1;
        buf_l_d    = i_left;
        buf_r_d    = i_right;
      end
    end
  end

  // Control state register, updated on the falling bit-clock edge.
  always_ff @(negedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      lrc_q      <= 1'b0;
      buf_full_q <= 1'b0;
      buf_l_q    <= '0;
      buf_r_q    <= '0;
      r_word_q   <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lrc_q      <= i_lrc;
      buf_full_q <= buf_full_d;
      buf_l_q    <= buf_l_d;
      buf_r_q    <= buf_r_d;
      r_word_q   <= r_word_d;
      underrun_q <= underrun_d;
    end
  end

  aud_slot_shifter #(
    .DATA_W (DATA_W)
  ) u_shifter (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (sh_clear),
    .i_load  (sh_load),
    .i_delay (SlotDelay),
    .i_word  (sh_word),
    .o_bit   (o_aud_dacdat)
  );

  assign o_state    = state_q;
  assign o_underrun = underrun_q;

endmodule

// File: tb/tb_aud_player_stereo.sv
// Directed bench: an I2S instance and a left-justified instance share all stimulus.
module tb_aud_player_stereo;

  logic        i_clk = 1'b0;
  logic        i_rst, i_lrc, i_en, i_valid;
  logic [15:0] i_left, i_right;
`ifdef AUD_PLAYER_MONO_EN
  logic        i_mono;
`endif
  logic        rdy_i2s, dat_i2s, ur_i2s, rdy_lj, dat_lj, ur_lj;
  logic [1:0]  st_i2s, st_lj;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] obs_i2s, obs_lj, exp_v;
  int          ur_i2s_cnt, ur_lj_cnt;
  logic        rdy_first;

  always #5 i_clk = ~i_clk;

  aud_player_stereo #(.DATA_W(16), .I2S_MODE(1)) dut_i2s (
    .i_clk(i_clk), .i_rst(i_rst), .i_lrc(i_lrc), .i_en(i_en), .i_valid(i_valid),
    .o_ready(rdy_i2s), .i_left(i_left), .i_right(i_right),
`ifdef AUD_PLAYER_MONO_EN
    .i_mono(i_mono),
`endif
    .o_aud_dacdat(dat_i2s), .o_state(st_i2s), .o_underrun(ur_i2s)
  );

  aud_player_stereo #(.DATA_W(16), .I2S_MODE(0)) dut_lj (
    .i_clk(i_clk), .i_rst(i_rst), .i_lrc(i_lrc), .i_en(i_en), .i_valid(i_valid),
    .o_ready(rdy_lj), .i_left(i_left), .i_right(i_right),
`ifdef AUD_PLAYER_MONO_EN
    .i_mono(i_mono),
`endif
    .o_aud_dacdat(dat_lj), .o_state(st_lj), .o_underrun(ur_lj)
  );

  // One active (falling) edge, then sample shortly after it.
  task automatic step();
    @(negedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_en = 1'b0; i_valid = 1'b0; i_lrc = 1'b0;
    i_left = '0; i_right = '0;
`ifdef AUD_PLAYER_MONO_EN
    i_mono = 1'b0;
`endif
    repeat (3) step();
    i_rst = 1'b0;
  endtask

  task automatic start_sync();
    i_en = 1'b1; i_lrc = 1'b1;
    step();
    step();
  endtask

  task automatic preload(input logic [15:0] l, input logic [15:0] r);
    i_left = l; i_right = r; i_valid = 1'b1;
    step();
    i_valid = 1'b0;
  endtask

  // Hold i_lrc for n edges, collecting serial bits first-bit-in-MSB order.
  task automatic run_half(input int n, input logic lrc, input logic vld_first);
    i_lrc = lrc;
    obs_i2s = '0; obs_lj = '0;
    for (int k = 0; k < n; k++) begin
      i_valid = vld_first && (k == 0);
      step();
      if (k == 0) rdy_first = rdy_i2s;
      obs_i2s = {obs_i2s[62:0], dat_i2s};
      obs_lj  = {obs_lj[62:0], dat_lj};
      ur_i2s_cnt += int'(ur_i2s);
      ur_lj_cnt  += int'(ur_lj);
    end
    i_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({st_i2s, dat_i2s, rdy_i2s, ur_i2s, st_lj, dat_lj, rdy_lj, ur_lj} !== 10'b0) begin
      failures++;
      $display("FAIL reset_state: got %b required 0", {st_i2s, dat_i2s, rdy_i2s, ur_i2s,
               st_lj, dat_lj, rdy_lj, ur_lj});
    end
    i_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      i_lrc = c[2];
      step();
      checks++;
      if ({st_i2s, dat_i2s, rdy_i2s, st_lj, dat_lj, rdy_lj} !== 8'b0) begin
        failures++;
        $display("FAIL idle_cycle_%0d: got %b required 0", c,
                 {st_i2s, dat_i2s, rdy_i2s, st_lj, dat_lj, rdy_lj});
      end
    end
    i_valid = 1'b0;
  endtask

  task automatic test_i2s_stereo();
    do_reset();
    start_sync();
    preload(16'hA5C3, 16'h1234);
    checks++;
    if (rdy_i2s !== 1'b0) begin
      failures++; $display("FAIL ready_when_full: got %b required 0", rdy_i2s);
    end
    ur_i2s_cnt = 0; ur_lj_cnt = 0;
    run_half(32, 1'b0, 1'b0);
    exp_v = {32'h0, 1'b0, 16'hA5C3, 15'h0};
    checks++;
    if (obs_i2s !== exp_v) begin
      failures++; $display("FAIL i2s_left: got %h required %h", obs_i2s, exp_v);
    end
    checks++;
    if (rdy_first !== 1'b1) begin
      failures++; $display("FAIL ready_after_consume: got %b required 1", rdy_first);
    end
    run_half(32, 1'b1, 1'b0);
    exp_v = {32'h0, 1'b0, 16'h1234, 15'h0};
    checks++;
    if (obs_i2s !== exp_v) begin
      failures++; $display("FAIL i2s_right: got %h required %h", obs_i2s, exp_v);
    end
    exp_v = {32'h0, 16'h1234, 16'h0};
    checks++;
    if (obs_lj !== exp_v) begin
      failures++; $display("FAIL lj_right_a: got %h required %h", obs_lj, exp_v);
    end
    checks++;
    if (ur_i2s_cnt + ur_lj_cnt !== 0) begin
      failures++; $display("FAIL i2s_no_underrun: got %0d required 0", ur_i2s_cnt + ur_lj_cnt);
    end
  endtask

  task automatic test_left_justified();
    do_reset();
    start_sync();
    preload(16'h8001, 16'h00FF);
    run_half(32, 1'b0, 1'b0);
    exp_v = {32'h0, 16'h8001, 16'h0};
    checks++;
    if (obs_lj !== exp_v) begin
      failures++; $display("FAIL lj_left: got %h required %h", obs_lj, exp_v);
    end
    run_half(32, 1'b1, 1'b0);
    exp_v = {32'h0, 16'h00FF, 16'h0};
    checks++;
    if (obs_lj !== exp_v) begin
      failures++; $display("FAIL lj_right: got %h required %h", obs_lj, exp_v);
    end
  endtask

  task automatic test_underrun_bypass();
    do_reset();
    start_sync();
    ur_i2s_cnt = 0; ur_lj_cnt = 0;
    run_half(32, 1'b0, 1'b0);
    checks++;
    if ({obs_i2s, obs_lj} !== 128'h0) begin
      failures++; $display("FAIL underrun_zeros: got %h %h required 0", obs_i2s, obs_lj);
    end
    checks++;
    if (ur_i2s_cnt !== 1 || ur_lj_cnt !== 1) begin
      failures++;
      $display("FAIL underrun_pulse: got %0d/%0d required 1/1", ur_i2s_cnt, ur_lj_cnt);
    end
    run_half(32, 1'b1, 1'b0);
    ur_i2s_cnt = 0; ur_lj_cnt = 0;
    i_left = 16'h5A5A; i_right = 16'h0F0F;
    run_half(32, 1'b0, 1'b1);
    exp_v = {32'h0, 1'b0, 16'h5A5A, 15'h0};
    checks++;
    if (obs_i2s !== exp_v) begin
      failures++; $display("FAIL bypass_left: got %h required %h", obs_i2s, exp_v);
    end
    checks++;
    if (ur_i2s_cnt + ur_lj_cnt !== 0) begin
      failures++; $display("FAIL bypass_no_pulse: got %0d required 0", ur_i2s_cnt + ur_lj_cnt);
    end
    run_half(32, 1'b1, 1'b0);
    exp_v = {32'h0, 16'h0F0F, 16'h0};
    checks++;
    if (obs_lj !== exp_v) begin
      failures++; $display("FAIL bypass_right: got %h required %h", obs_lj, exp_v);
    end
  endtask

  task automatic test_short_slot_disable();
    do_reset();
    start_sync();
    preload(16'hA5C3, 16'h1234);
    run_half(8, 1'b0, 1'b0);
    checks++;
    if (obs_lj !== 64'hA5 || obs_i2s !== 64'h52) begin
      failures++;
      $display("FAIL short_left: got %h/%h required a5/52", obs_lj[7:0], obs_i2s[7:0]);
    end
    run_half(8, 1'b1, 1'b0);
    checks++;
    if (obs_lj !== 64'h12 || obs_i2s !== 64'h09) begin
      failures++;
      $display("FAIL short_right: got %h/%h required 12/09", obs_lj[7:0], obs_i2s[7:0]);
    end
    run_half(3, 1'b0, 1'b0);
    checks++;
    if (st_i2s !== 2'd2 || st_lj !== 2'd2) begin
      failures++; $display("FAIL in_left: got %0d/%0d required 2/2", st_i2s, st_lj);
    end
    i_en = 1'b0;
    step();
    checks++;
    if ({st_i2s, dat_i2s, rdy_i2s, ur_i2s, st_lj, dat_lj, rdy_lj, ur_lj} !== 10'b0) begin
      failures++;
      $display("FAIL disable_idle: got %b required 0", {st_i2s, dat_i2s, rdy_i2s, ur_i2s,
               st_lj, dat_lj, rdy_lj, ur_lj});
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    start_sync();
    preload(16'hFFFF, 16'hFFFF);
    run_half(5, 1'b0, 1'b0);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    checks++;
    if ({st_i2s, dat_i2s, rdy_i2s, ur_i2s, st_lj, dat_lj, rdy_lj, ur_lj} !== 10'b0) begin
      failures++;
      $display("FAIL mid_reset: got %b required 0", {st_i2s, dat_i2s, rdy_i2s, ur_i2s,
               st_lj, dat_lj, rdy_lj, ur_lj});
    end
  endtask

`ifdef AUD_PLAYER_MONO_EN
  task automatic test_mono();
    do_reset();
    i_mono = 1'b1;
    start_sync();
    preload(16'h7FFF, 16'h7FFF);
    run_half(32, 1'b0, 1'b0);
    exp_v = {32'h0, 1'b0, 16'h7FFF, 15'h0};
    checks++;
    if (obs_i2s !== exp_v) begin
      failures++; $display("FAIL mono_max_left: got %h required %h", obs_i2s, exp_v);
    end
    run_half(32, 1'b1, 1'b0);
    checks++;
    if (obs_i2s !== exp_v) begin
      failures++; $display("FAIL mono_max_right: got %h required %h", obs_i2s, exp_v);
    end
    i_left = 16'h8000; i_right = 16'h0000;
    run_half(32, 1'b0, 1'b1);
    exp_v = {32'h0, 1'b0, 16'hC000, 15'h0};
    checks++;
    if (obs_i2s !== exp_v) begin
      failures++; $display("FAIL mono_neg_left: got %h required %h", obs_i2s, exp_v);
    end
    run_half(32, 1'b1, 1'b0);
    exp_v = {32'h0, 16'hC000, 16'h0};
    checks++;
    if (obs_lj !== exp_v) begin
      failures++; $display("FAIL mono_neg_right: got %h required %h", obs_lj, exp_v);
    end
    i_mono = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_i2s_stereo();
    test_left_justified();
    test_underrun_bypass();
    test_short_slot_disable();
    test_mid_reset();
`ifdef AUD_PLAYER_MONO_EN
    test_mono();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
